// File: rtl/uart_reg_master.sv
// uart_reg_master: host-side initiator of the UART register-access protocol (W/R command frames).
// Optional read-reply timeout enabled by defining UART_REG_MASTER_TIMEOUT_EN.
module uart_reg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_timeout_o,
  output logic       busy_o,
  output logic [7:0] tx_data_o,
  output logic       tx_wr_o,
  input  logic       tx_done_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_CMD,
    S_SEND_ADDR,
    S_WAIT_ADDR,
    S_SEND_DATA,
    S_WAIT_DATA,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  state_t     r_state;
  logic       r_write;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rx_byte;
  logic       r_rx_got;
  logic       r_ready;
  logic       r_tx_wr;
  logic [7:0] r_tx_data;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_reg_master: TIMEOUT_CYCLES must be >= 2");
  end

`ifdef UART_REG_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= S_IDLE;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rx_byte     <= '0;
      r_rx_got      <= 1'b0;
      r_ready       <= 1'b1;
      r_tx_wr       <= 1'b0;
      r_tx_data     <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
`ifdef UART_REG_MASTER_TIMEOUT_EN
      r_cnt         <= '0;
`endif
    end else begin
      r_tx_wr     <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_write   <= req_write_i;
            r_addr    <= req_addr_i;
            r_wdata   <= req_wdata_i;
            r_rx_got  <= 1'b0;
            r_ready   <= 1'b0;
            r_tx_data <= req_write_i ? CMD_WRITE : CMD_READ;
            r_tx_wr   <= 1'b1;
            r_state   <= S_SEND_CMD;
          end
        end
        S_SEND_CMD:  r_state <= S_WAIT_CMD;
        S_WAIT_CMD: begin
          if (tx_done_i) begin
            r_tx_data <= r_addr;
            r_tx_wr   <= 1'b1;
            r_state   <= S_SEND_ADDR;
          end
        end
        S_SEND_ADDR: r_state <= S_WAIT_ADDR;
        S_WAIT_ADDR: begin
          // A fast reply can arrive while the address byte is still draining; keep only the first.
          if (!r_write && rx_done_i && !r_rx_got) begin
            r_rx_byte <= rx_data_i;
            r_rx_got  <= 1'b1;
          end
          if (tx_done_i) begin
            if (r_write) begin
              r_tx_data <= r_wdata;
              r_tx_wr   <= 1'b1;
              r_state   <= S_SEND_DATA;
            end else if (r_rx_got || rx_done_i) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_rdata   <= r_rx_got ? r_rx_byte : rx_data_i;
              r_rsp_timeout <= 1'b0;
              r_state       <= S_DONE;
            end else begin
`ifdef UART_REG_MASTER_TIMEOUT_EN
              r_cnt   <= '0;
`endif
              r_state <= S_WAIT_RSP;
            end
          end
        end
        S_SEND_DATA: r_state <= S_WAIT_DATA;
        S_WAIT_DATA: begin
          if (tx_done_i) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_DONE;
          end
        end
        S_WAIT_RSP: begin
          if (rx_done_i) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= rx_data_i;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_DONE;
          end
`ifdef UART_REG_MASTER_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = r_ready;
  assign busy_o        = ~r_ready;
  assign tx_wr_o       = r_tx_wr;
  assign tx_data_o     = r_tx_data;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_timeout_o = r_rsp_timeout;

endmodule
